sync_sram_req_ctrl: RTL and testbench
=====================================

Name: sync_sram_req_ctrl

Overview:
- Requester-side controller for a single-port (1rw) synchronous-read SRAM.
- Accepts val/rdy memory requests (read or byte-masked write) and drives the SRAM read/write port.
- Captures the SRAM's one-cycle-late read data and returns in-order val/rdy responses.
- A 2-entry response buffer absorbs backpressure, because SRAM read data is valid for one cycle only.

Parameters:
- p_data_nbits, default 32: data word width.
- p_num_entries, default 256: SRAM depth in words.
- c_addr_nbits, default $clog2(p_num_entries): address width (derived, not set externally).
- c_data_nbytes, default (p_data_nbits+7)/8: byte-enable width (derived, not set externally).

Ports:
- clk, input, 1: clock; all state updates on posedge.
- reset, input, 1: synchronous, active-low reset.
- req_val, input, 1: request valid.
- req_rdy, output, 1: request ready.
- req_type, input, 1: 0 = read, 1 = write.
- req_addr, input, c_addr_nbits: word address.
- req_byte_en, input, c_data_nbytes: write byte mask (ignored for reads).
- req_data, input, p_data_nbits: write data.
- resp_val, output, 1: response valid.
- resp_rdy, input, 1: response ready.
- resp_type, output, 1: echoes req_type of the matching request.
- resp_data, output, p_data_nbits: read data; all zeros for writes.
- sram_read_en, output, 1: SRAM read enable.
- sram_read_addr, output, c_addr_nbits: SRAM read address.
- sram_read_data, input, p_data_nbits: SRAM read data, valid the cycle after sram_read_en.
- sram_write_en, output, 1: SRAM write enable.
- sram_write_byte_en, output, c_data_nbytes: SRAM byte enables.
- sram_write_addr, output, c_addr_nbits: SRAM write address.
- sram_write_data, output, p_data_nbits: SRAM write data.

Behaviour:
- Reset is synchronous and active-low (reset==0 sampled at posedge clk).
- While reset==0, req_rdy=0, resp_val=0, sram_read_en=0 and sram_write_en=0, all combinationally.
- At the reset edge: inflight_val=0, buf_count=0, buffer head/tail pointers=0.
- Reset mid-operation discards in-flight and buffered responses with no response emitted.
- Request fire: req_fire = req_val & req_rdy.
- Issue is combinational in the fire cycle:
  - sram_read_en = req_fire & ~req_type.
  - sram_write_en = req_fire & req_type.
  - Both address outputs = req_addr.
  - sram_write_data = req_data.
  - sram_write_byte_en = req_byte_en when writing, else 0.
- sram_read_en and sram_write_en are never both 1.
- In-flight stage: inflight_val and inflight_type are registered from req_fire/req_type each non-reset edge.
- Candidate response in cycle N+1 = {inflight_type, inflight_type ? 0 : sram_read_data}.
- Response buffer: 2-entry FIFO (buf_count 0..2) storing {type, data}, pointers wrapping mod 2.
- Response output:
  - resp_val = (buf_count>0) | inflight_val.
  - Output comes from the buffer head if buf_count>0, else from the candidate (bypass).
- Dequeue: resp_val & resp_rdy & buf_count>0.
- Enqueue candidate: inflight_val & ~(buf_count==0 & resp_rdy), i.e. bypass when the buffer is empty and the consumer is ready.
- Simultaneous enqueue and dequeue leaves buf_count unchanged, with both pointers advancing.
- Flow control: req_rdy = reset & ((buf_count + inflight_val) < 2). This guarantees no buffer overflow and no lost read data.
- Latency: a request fired in cycle N gives its earliest response in cycle N+1 (resp_val asserted that cycle).
- Throughput: 1 request/cycle sustained while resp_rdy=1.
- Ordering: responses are returned strictly in request order.
- Assertions, checked at posedge when reset==1:
  - req_val and resp_rdy are not X.
  - On req_fire, req_type and req_addr are not X and req_addr < p_num_entries.
  - buf_count never exceeds 2.
- An out-of-range address is a protocol error: the assertion fires and the RTL does not mask it.

Test Plan:
1. Write then read: write addr 3 data 0xdeadbeef byte_en 0xF, then read addr 3 with resp_rdy=1 -> write resp (type 1, data 0) at N+1; read resp (type 0, data 0xdeadbeef) one cycle after read fire.
2. Byte mask: prefill addr 5 = 0x11223344, then write 0xaabbccdd byte_en 0b0101 and read addr 5 -> 0x11bb33dd.
3. Back-to-back: 8 reads of addrs 0..7 on consecutive cycles, resp_rdy=1 -> req_rdy stays 1 and 8 in-order responses arrive on consecutive cycles.
4. Backpressure: resp_rdy=0 while reads are issued -> exactly 2 requests accepted, then req_rdy=0; resp_rdy=1 -> both responses drain in order, then req_rdy returns to 1.
5. Random stall: random resp_rdy at 50% with a random read/write mix for 500 requests -> all responses match a reference memory model, in order, with no X on the SRAM enables.
6. Reset mid-flight: 2 responses buffered, then reset=0 for 1 cycle -> resp_val=0 and req_rdy=0 during reset; afterwards buf_count=0, no stale response, and a new read returns correct data.

Source files
------------

// File: rtl/sync_sram_req_ctrl.sv
// rtl/sync_sram_req_ctrl.sv - requester-side val/rdy controller for a 1rw synchronous-read SRAM
module sync_sram_req_ctrl #(
    parameter int p_data_nbits = 32,
    parameter int p_num_entries = 256,
    localparam int c_addr_nbits = $clog2(p_num_entries),
    localparam int c_data_nbytes = (p_data_nbits + 7) / 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_val,
    output logic                     req_rdy,
    input  logic                     req_type,
    input  logic [c_addr_nbits-1:0]  req_addr,
    input  logic [c_data_nbytes-1:0] req_byte_en,
    input  logic [p_data_nbits-1:0]  req_data,
    output logic                     resp_val,
    input  logic                     resp_rdy,
    output logic                     resp_type,
    output logic [p_data_nbits-1:0]  resp_data,
    output logic                     sram_read_en,
    output logic [c_addr_nbits-1:0]  sram_read_addr,
    input  logic [p_data_nbits-1:0]  sram_read_data,
    output logic                     sram_write_en,
    output logic [c_data_nbytes-1:0] sram_write_byte_en,
    output logic [c_addr_nbits-1:0]  sram_write_addr,
    output logic [p_data_nbits-1:0]  sram_write_data
);

    logic                    req_fire;
    logic                    inflight_val;
    logic                    inflight_type;
    logic [1:0]              buf_count;
    logic                    buf_head;
    logic                    buf_tail;
    logic                    buf_type [2];
    logic [p_data_nbits-1:0] buf_data [2];
    logic                    buf_empty;
    logic [1:0]              occupancy;
    logic                    cand_type;
    logic [p_data_nbits-1:0] cand_data;
    logic                    enq;
    logic                    deq;

    // Buffer entries plus the read in flight must fit in two slots, so the
    // one-cycle SRAM data always has somewhere to land.
    assign buf_empty = (buf_count == 2'd0);
    assign occupancy = buf_count + {1'b0, inflight_val};
    assign req_rdy   = reset & (occupancy < 2'd2);
    assign req_fire  = req_val & req_rdy;

    assign sram_read_en       = req_fire & ~req_type;
    assign sram_write_en      = req_fire & req_type;
    assign sram_read_addr     = req_addr;
    assign sram_write_addr    = req_addr;
    assign sram_write_data    = req_data;
    assign sram_write_byte_en = (req_fire & req_type) ? req_byte_en : '0;

    assign cand_type = inflight_type;
    assign cand_data = inflight_type ? '0 : sram_read_data;

    assign resp_val  = reset & (~buf_empty | inflight_val);
    assign resp_type = buf_empty ? cand_type : buf_type[buf_head];
    assign resp_data = buf_empty ? cand_data : buf_data[buf_head];

    assign deq = resp_val & resp_rdy & ~buf_empty;
    assign enq = inflight_val & ~(buf_empty & resp_rdy);

    always_ff @(posedge clk) begin
        if (!reset) begin
            inflight_val <= 1'b0;
            buf_count    <= 2'd0;
            buf_head     <= 1'b0;
            buf_tail     <= 1'b0;
        end else begin
            inflight_val  <= req_fire;
            inflight_type <= req_type;
            if (enq) begin
                buf_tail <= ~buf_tail;
            end
            if (deq) begin
                buf_head <= ~buf_head;
            end
            case ({enq, deq})
                2'b10:   buf_count <= buf_count + 2'd1;
                2'b01:   buf_count <= buf_count - 2'd1;
                default: buf_count <= buf_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset && enq) begin
            buf_type[buf_tail] <= cand_type;
            buf_data[buf_tail] <= cand_data;
        end
    end

    // Protocol checks; an out-of-range address is left unmasked on purpose.
    always @(posedge clk) begin
        if (reset) begin
            assert (!$isunknown(req_val));
            assert (!$isunknown(resp_rdy));
            if (req_fire) begin
                assert (!$isunknown(req_type));
                assert (!$isunknown(req_addr));
                assert (32'(req_addr) < p_num_entries);
            end
            assert (buf_count <= 2'd2);
        end
    end

endmodule

// File: tb/tb_sync_sram_req_ctrl.sv
// tb/tb_sync_sram_req_ctrl.sv - directed self-checking bench for sync_sram_req_ctrl
module tb_sync_sram_req_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_val;
    logic        req_rdy;
    logic        req_type;
    logic [7:0]  req_addr;
    logic [3:0]  req_byte_en;
    logic [31:0] req_data;
    logic        resp_val;
    logic        resp_rdy;
    logic        resp_type;
    logic [31:0] resp_data;
    logic        sram_read_en;
    logic [7:0]  sram_read_addr;
    logic [31:0] sram_read_data;
    logic        sram_write_en;
    logic [3:0]  sram_write_byte_en;
    logic [7:0]  sram_write_addr;
    logic [31:0] sram_write_data;

    int tests = 0;
    int fails = 0;
    logic [32:0] exp_q [$];
    logic [31:0] sram_mem [256];
    logic [31:0] ref_mem [256];

    sync_sram_req_ctrl dut (
        .clk                (clk),
        .reset              (reset),
        .req_val            (req_val),
        .req_rdy            (req_rdy),
        .req_type           (req_type),
        .req_addr           (req_addr),
        .req_byte_en        (req_byte_en),
        .req_data           (req_data),
        .resp_val           (resp_val),
        .resp_rdy           (resp_rdy),
        .resp_type          (resp_type),
        .resp_data          (resp_data),
        .sram_read_en       (sram_read_en),
        .sram_read_addr     (sram_read_addr),
        .sram_read_data     (sram_read_data),
        .sram_write_en      (sram_write_en),
        .sram_write_byte_en (sram_write_byte_en),
        .sram_write_addr    (sram_write_addr),
        .sram_write_data    (sram_write_data)
    );

    always #5 clk = ~clk;

    // Synchronous-read SRAM: data appears the cycle after the read enable.
    always @(posedge clk) begin
        if (sram_write_en) begin
            for (int b = 0; b < 4; b++) begin
                if (sram_write_byte_en[b]) begin
                    sram_mem[sram_write_addr][8*b +: 8] <= sram_write_data[8*b +: 8];
                end
            end
        end
        if (sram_read_en) begin
            sram_read_data <= sram_mem[sram_read_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pops on response handshake, pushes model results on request fire.
    task automatic monitor();
        logic [31:0] nd;
        if (!reset) begin
            exp_q.delete();
            return;
        end
        check("sram_en_excl", 64'(($isunknown({sram_read_en, sram_write_en})) || (sram_read_en && sram_write_en)), 64'd0);
        if (resp_val && resp_rdy) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL resp_unexpected observed=0x%0h expected=none", {resp_type, resp_data});
            end else begin
                check("resp_order", 64'({resp_type, resp_data}), 64'(exp_q.pop_front()));
            end
        end
        if (req_val && req_rdy) begin
            if (req_type) begin
                nd = ref_mem[req_addr];
                for (int b = 0; b < 4; b++) begin
                    if (req_byte_en[b]) nd[8*b +: 8] = req_data[8*b +: 8];
                end
                ref_mem[req_addr] = nd;
                exp_q.push_back({1'b1, 32'd0});
            end else begin
                exp_q.push_back({1'b0, ref_mem[req_addr]});
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic advance();
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic drive(input logic t, input logic [7:0] a, input logic [3:0] be, input logic [31:0] d);
        req_val     = 1'b1;
        req_type    = t;
        req_addr    = a;
        req_byte_en = be;
        req_data    = d;
    endtask

    initial begin
        int          sent;
        int          cyc;
        logic [31:0] e;

        reset = 1'b0; req_val = 1'b1; req_type = 1'b0; req_addr = 8'd0;
        req_byte_en = 4'h0; req_data = 32'd0; resp_rdy = 1'b0;

        // Reset: everything held off combinationally.
        settle();
        check("rst_req_rdy", 64'(req_rdy), 64'd0);
        check("rst_resp_val", 64'(resp_val), 64'd0);
        check("rst_read_en", 64'(sram_read_en), 64'd0);
        advance();
        req_type = 1'b1;
        settle();
        check("rst_write_en", 64'(sram_write_en), 64'd0);
        advance();

        reset = 1'b1; req_val = 1'b0; resp_rdy = 1'b1;
        settle();
        check("idle_req_rdy", 64'(req_rdy), 64'd1);
        check("idle_resp_val", 64'(resp_val), 64'd0);
        advance();

        // Prefill addrs 0..31 with 0xc0de0000+addr.
        for (int a = 0; a < 32; a++) begin
            drive(1'b1, 8'(a), 4'hf, 32'hc0de0000 + 32'(a));
            tick();
        end
        req_val = 1'b0;
        tick();
        tick();

        // Back-to-back reads of 0..7.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 8'(i), 4'h0, 32'd0);
            settle();
            check("b2b_req_rdy", 64'(req_rdy), 64'd1);
            if (i > 0) begin
                e = 32'hc0de0000 + 32'(i - 1);
                check("b2b_resp", 64'({resp_val, resp_type, resp_data}), 64'({2'b10, e}));
            end
            advance();
        end
        req_val = 1'b0;
        settle();
        check("b2b_last", 64'({resp_val, resp_type, resp_data}), 64'({2'b10, 32'hc0de0007}));
        advance();

        // Write then read addr 3.
        drive(1'b1, 8'd3, 4'hf, 32'hdeadbeef);
        settle();
        check("wr_en", 64'({sram_write_en, sram_read_en}), 64'h2);
        check("wr_addr", 64'(sram_write_addr), 64'd3);
        check("wr_be", 64'(sram_write_byte_en), 64'hf);
        check("wr_data", 64'(sram_write_data), 64'hdeadbeef);
        advance();
        drive(1'b0, 8'd3, 4'hf, 32'd0);
        settle();
        check("wr_resp", 64'({resp_val, resp_type, resp_data}), 64'({2'b11, 32'd0}));
        check("rd_en", 64'({sram_write_en, sram_read_en}), 64'h1);
        check("rd_addr", 64'(sram_read_addr), 64'd3);
        check("rd_be_zero", 64'(sram_write_byte_en), 64'h0);
        advance();
        req_val = 1'b0;
        settle();
        check("rd_resp", 64'({resp_val, resp_type, resp_data}), 64'({2'b10, 32'hdeadbeef}));
        advance();

        // Byte mask on addr 5.
        drive(1'b1, 8'd5, 4'hf, 32'h11223344);
        tick();
        drive(1'b1, 8'd5, 4'b0101, 32'haabbccdd);
        tick();
        drive(1'b0, 8'd5, 4'h0, 32'd0);
        tick();
        req_val = 1'b0;
        settle();
        check("mask_resp", 64'({resp_val, resp_type, resp_data}), 64'({2'b10, 32'h11bb33dd}));
        advance();

        // Backpressure: two accepted, third held until drain.
        resp_rdy = 1'b0;
        drive(1'b0, 8'd8, 4'h0, 32'd0);
        settle();
        check("bp_rdy_a", 64'(req_rdy), 64'd1);
        advance();
        drive(1'b0, 8'd9, 4'h0, 32'd0);
        settle();
        check("bp_rdy_b", 64'(req_rdy), 64'd1);
        advance();
        drive(1'b0, 8'd10, 4'h0, 32'd0);
        settle();
        check("bp_rdy_c", 64'(req_rdy), 64'd0);
        advance();
        settle();
        check("bp_rdy_d", 64'(req_rdy), 64'd0);
        check("bp_head_d", 64'({resp_val, resp_data}), 64'({1'b1, 32'hc0de0008}));
        advance();
        resp_rdy = 1'b1;
        settle();
        check("bp_rdy_e", 64'(req_rdy), 64'd0);
        check("bp_head_e", 64'({resp_val, resp_data}), 64'({1'b1, 32'hc0de0008}));
        advance();
        settle();
        check("bp_rdy_f", 64'(req_rdy), 64'd1);
        check("bp_head_f", 64'({resp_val, resp_data}), 64'({1'b1, 32'hc0de0009}));
        advance();
        req_val = 1'b0;
        settle();
        check("bp_bypass", 64'({resp_val, resp_data}), 64'({1'b1, 32'hc0de000a}));
        advance();

        // Random stall with mixed traffic on addrs 16..31.
        sent = 0;
        cyc = 0;
        while (sent < 500 && cyc < 5000) begin
            req_val     = ($urandom_range(3, 0) != 0);
            req_type    = 1'($urandom_range(1, 0));
            req_addr    = 8'(16 + $urandom_range(15, 0));
            req_byte_en = 4'($urandom);
            req_data    = $urandom;
            resp_rdy    = 1'($urandom_range(1, 0));
            settle();
            if (req_val && req_rdy) sent++;
            advance();
            cyc++;
        end
        check("rand_sent", 64'(sent), 64'd500);
        req_val = 1'b0;
        resp_rdy = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        check("rand_drained", 64'(exp_q.size()), 64'd0);

        // Reset with two responses buffered.
        resp_rdy = 1'b0;
        drive(1'b0, 8'd6, 4'h0, 32'd0);
        tick();
        drive(1'b0, 8'd7, 4'h0, 32'd0);
        tick();
        req_val = 1'b0;
        tick();
        settle();
        check("mid_full", 64'({resp_val, req_rdy}), 64'h2);
        advance();
        reset = 1'b0;
        drive(1'b0, 8'd6, 4'h0, 32'd0);
        settle();
        check("mid_rst_resp_val", 64'(resp_val), 64'd0);
        check("mid_rst_req_rdy", 64'(req_rdy), 64'd0);
        check("mid_rst_read_en", 64'(sram_read_en), 64'd0);
        advance();
        reset = 1'b1;
        req_val = 1'b0;
        resp_rdy = 1'b1;
        settle();
        check("post_rst_resp_val", 64'(resp_val), 64'd0);
        check("post_rst_req_rdy", 64'(req_rdy), 64'd1);
        advance();
        drive(1'b0, 8'd4, 4'h0, 32'd0);
        tick();
        req_val = 1'b0;
        settle();
        check("post_rst_read", 64'({resp_val, resp_type, resp_data}), 64'({2'b10, 32'hc0de0004}));
        advance();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
